// File: rtl/lock_ctrl.sv
// Supervisory controller for the sequence-detecting lock core: button edge detection, door hold, failed-attempt lockout.
// Optional entry timeout is enabled by defining LOCK_CTRL_TIMEOUT_EN.
module lock_ctrl #(
   parameter int unsigned CODE_LEN       = 5,
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned OPEN_CYCLES    = 50000000,
   parameter int unsigned LOCKOUT_CYCLES = 500000000,
   parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn0,
   input  logic       btn1,
   input  logic       core_unlock,
   output logic       core_b0,
   output logic       core_b1,
   output logic       core_rst,
   output logic       door_open,
   output logic       lockout,
   output logic [3:0] fail_count,
   output logic [1:0] ctrl_state
);

   localparam int unsigned MAX_OL  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TMR_MAX = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned FAIL_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENTRY   = 2'd1,
      S_OPEN    = 2'd2,
      S_LOCKOUT = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
   logic [1:0]          judge_q, judge_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic                btn0_q, btn1_q;
   logic                core_b0_q, core_b0_d;
   logic                core_b1_q, core_b1_d;
   logic                core_rst_q, core_rst_d;
   logic                door_open_q, door_open_d;
   logic                lockout_q, lockout_d;
   logic                press0, press1;
   logic [FAIL_W-1:0]   fail_inc;

   // A rise is a digit only if the other button is idle, so chords never count
   assign press0 = btn0 & ~btn0_q & ~btn1;
   assign press1 = btn1 & ~btn1_q & ~btn0;
   assign fail_inc = (fail_cnt_q == 4'hF) ? fail_cnt_q : fail_cnt_q + FAIL_W'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      digit_cnt_d = digit_cnt_q;
      judge_d     = judge_q;
      timer_d     = timer_q;
      fail_cnt_d  = fail_cnt_q;
      core_b0_d   = 1'b0;
      core_b1_d   = 1'b0;
      core_rst_d  = 1'b0;
      door_open_d = 1'b0;
      lockout_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (press0 || press1) begin
               core_b0_d   = press0;
               core_b1_d   = press1;
               digit_cnt_d = CNT_W'(1);
               judge_d     = 2'd0;
               timer_d     = TMR_W'(TIMEOUT_CYCLES);
               state_d     = S_ENTRY;
            end
         end

         S_ENTRY: begin
            if (core_unlock) begin
               state_d     = S_OPEN;
               door_open_d = 1'b1;
               fail_cnt_d  = '0;
               digit_cnt_d = '0;
               judge_d     = 2'd0;
               timer_d     = TMR_W'(OPEN_CYCLES - 1);
            end else if (digit_cnt_q == CNT_W'(CODE_LEN)) begin
               // Judge window: pulse cycle plus two more cycles for the core to answer
               if (judge_q == 2'd2) begin
                  fail_cnt_d  = fail_inc;
                  core_rst_d  = 1'b1;
                  digit_cnt_d = '0;
                  judge_d     = 2'd0;
                  if (fail_inc >= FAIL_W'(MAX_FAIL)) begin
                     state_d   = S_LOCKOUT;
                     lockout_d = 1'b1;
                     timer_d   = TMR_W'(LOCKOUT_CYCLES - 1);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  judge_d = judge_q + 2'd1;
               end
            end else if (press0 || press1) begin
               core_b0_d   = press0;
               core_b1_d   = press1;
               digit_cnt_d = digit_cnt_q + CNT_W'(1);
               timer_d     = TMR_W'(TIMEOUT_CYCLES);
            end
`ifdef LOCK_CTRL_TIMEOUT_EN
            else if (timer_q == '0) begin
               core_rst_d  = 1'b1;
               digit_cnt_d = '0;
               state_d     = S_IDLE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
`else
`endif
         end

         S_OPEN: begin
            if (timer_q == '0) begin
               core_rst_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               door_open_d = 1'b1;
               timer_d     = timer_q - TMR_W'(1);
            end
         end

         S_LOCKOUT: begin
            if (timer_q == '0) begin
               fail_cnt_d = '0;
               state_d    = S_IDLE;
            end else begin
               lockout_d  = 1'b1;
               core_rst_d = 1'b1;
               timer_d    = timer_q - TMR_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; core_rst is asserted for the cycle after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         digit_cnt_q <= '0;
         judge_q     <= 2'd0;
         timer_q     <= '0;
         fail_cnt_q  <= '0;
         btn0_q      <= 1'b0;
         btn1_q      <= 1'b0;
         core_b0_q   <= 1'b0;
         core_b1_q   <= 1'b0;
         core_rst_q  <= 1'b1;
         door_open_q <= 1'b0;
         lockout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         digit_cnt_q <= digit_cnt_d;
         judge_q     <= judge_d;
         timer_q     <= timer_d;
         fail_cnt_q  <= fail_cnt_d;
         btn0_q      <= btn0;
         btn1_q      <= btn1;
         core_b0_q   <= core_b0_d;
         core_b1_q   <= core_b1_d;
         core_rst_q  <= core_rst_d;
         door_open_q <= door_open_d;
         lockout_q   <= lockout_d;
      end
   end

   assign core_b0    = core_b0_q;
   assign core_b1    = core_b1_q;
   assign core_rst   = core_rst_q;
   assign door_open  = door_open_q;
   assign lockout    = lockout_q;
   assign fail_count = fail_cnt_q;
   assign ctrl_state = state_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: cycle table for press detection and attempt judging, plus open/lockout/reset/timeout sequences.
// Honours LOCK_CTRL_TIMEOUT_EN to select the expected timeout behaviour.
module tb_lock_ctrl;

   logic       clk, rst, btn0, btn1, core_unlock;
   logic       core_b0, core_b1, core_rst, door_open, lockout;
   logic [3:0] fail_count;
   logic [1:0] ctrl_state;

   int checks   = 0;
   int failures = 0;

   lock_ctrl #(
      .CODE_LEN(5), .MAX_FAIL(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .btn0(btn0), .btn1(btn1), .core_unlock(core_unlock),
      .core_b0(core_b0), .core_b1(core_b1), .core_rst(core_rst), .door_open(door_open),
      .lockout(lockout), .fail_count(fail_count), .ctrl_state(ctrl_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Lock core model: unlocks on the 5-digit sequence 0,1,0,1,1; sticky until core_rst
   logic [4:0] m_sh;
   logic [2:0] m_cnt;
   logic       m_unlock;
   always @(posedge clk) begin
      if (rst || core_rst) begin
         m_sh <= '0; m_cnt <= '0; m_unlock <= 1'b0;
      end else if (core_b0 || core_b1) begin
         m_sh <= {m_sh[3:0], core_b1};
         if (m_cnt != 3'd5) m_cnt <= m_cnt + 3'd1;
         if (m_cnt == 3'd4 && {m_sh[3:0], core_b1} == 5'b01011) m_unlock <= 1'b1;
      end
   end
   assign core_unlock = m_unlock;

   // Free-running activity counters; tests take differences
   int door_cyc = 0, lock_cyc = 0, lock_rst_cyc = 0, lock_pulses = 0, both_cnt = 0;
   always @(negedge clk) begin
      if (door_open) door_cyc++;
      if (lockout) begin
         lock_cyc++;
         if (core_rst) lock_rst_cyc++;
         if (core_b0 || core_b1) lock_pulses++;
      end
      if (core_b0 && core_b1) both_cnt++;
   end

   typedef struct {
      logic       rst, b0, b1;
      logic       e_b0, e_b1, e_rst;
      logic [1:0] e_st;
      logic [3:0] e_fail;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic r, input logic i0, input logic i1, input logic o0,
                               input logic o1, input logic orst, input logic [1:0] st,
                               input logic [3:0] fl);
      vec_t v;
      v.rst = r; v.b0 = i0; v.b1 = i1; v.e_b0 = o0; v.e_b1 = o1; v.e_rst = orst;
      v.e_st = st; v.e_fail = fl;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit which, input int hold, input int gap);
      if (which) btn1 = 1'b1; else btn0 = 1'b1;
      repeat (hold) step();
      btn0 = 1'b0; btn1 = 1'b0;
      repeat (gap) step();
   endtask

   task automatic enter_code_ok();
      press(0, 3, 3); press(1, 3, 3); press(0, 3, 3); press(1, 3, 3);
   endtask

   initial begin
      int base_a, base_b, base_c;
      bit seen;
      rst = 1'b1; btn0 = 1'b0; btn1 = 1'b0;

      // Fields: rst,btn0,btn1 | core_b0,core_b1,core_rst,ctrl_state,fail_count after the edge
      add(1,0,0, 0,0,1,2'd0,4'd0);
      add(0,0,0, 0,0,0,2'd0,4'd0);
      add(0,1,1, 0,0,0,2'd0,4'd0);   // simultaneous rise ignored
      add(0,0,0, 0,0,0,2'd0,4'd0);
      add(0,1,0, 1,0,0,2'd1,4'd0);   // digit 1
      add(0,1,1, 0,0,0,2'd1,4'd0);   // btn1 rises while btn0 held
      add(0,1,0, 0,0,0,2'd1,4'd0);
      add(0,0,0, 0,0,0,2'd1,4'd0);
      add(0,0,1, 0,1,0,2'd1,4'd0);   // digit 2, then held 10 cycles total
      for (int i = 0; i < 9; i++) add(0,0,1, 0,0,0,2'd1,4'd0);
      add(0,0,0, 0,0,0,2'd1,4'd0);
      add(0,1,0, 1,0,0,2'd1,4'd0);   // digit 3
      add(0,0,0, 0,0,0,2'd1,4'd0);
      add(0,1,0, 1,0,0,2'd1,4'd0);   // digit 4
      add(0,0,0, 0,0,0,2'd1,4'd0);
      add(0,0,1, 0,1,0,2'd1,4'd0);   // digit 5 (wrong code)
      add(0,0,0, 0,0,0,2'd1,4'd0);
      add(0,1,0, 0,0,0,2'd1,4'd0);   // press inside judge window ignored
      add(0,0,0, 0,0,1,2'd0,4'd1);   // failure
      add(0,0,0, 0,0,0,2'd0,4'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; btn0 = vecs[i].b0; btn1 = vecs[i].b1;
         step();
         chk($sformatf("vec%0d{b0,b1,crst,st,fail,door,lock}", i),
             32'({core_b0, core_b1, core_rst, ctrl_state, fail_count, door_open, lockout}),
             32'({vecs[i].e_b0, vecs[i].e_b1, vecs[i].e_rst, vecs[i].e_st, vecs[i].e_fail, 2'b00}));
      end
      btn0 = 1'b0; btn1 = 1'b0;

      // Correct code opens the door for 8 cycles and clears fail_count
      base_a = door_cyc;
      enter_code_ok();
      press(1, 3, 3);
      chk("open_door_hi", 32'(door_open), 32'd1);
      chk("open_fail_clr", 32'(fail_count), 32'd0);
      chk("open_state", 32'(ctrl_state), 32'd2);
      for (int i = 0; i < 20 && door_open; i++) step();
      chk("open_door_dropped", 32'(door_open), 32'd0);
      chk("open_door_cycles", 32'(door_cyc - base_a), 32'd8);
      chk("open_exit_crst", 32'(core_rst), 32'd1);
      chk("open_exit_state", 32'(ctrl_state), 32'd0);
      step();
      chk("open_crst_single", 32'(core_rst), 32'd0);

      // Three wrong codes then lockout
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) begin
            base_a = lock_cyc; base_b = lock_rst_cyc; base_c = lock_pulses;
         end
         repeat (5) press(0, 3, 3);
         chk($sformatf("wrong%0d_fail", k), 32'(fail_count), 32'(k));
         chk($sformatf("wrong%0d_lock", k), 32'(lockout), (k == 3) ? 32'd1 : 32'd0);
         chk($sformatf("wrong%0d_state", k), 32'(ctrl_state), (k == 3) ? 32'd3 : 32'd0);
      end
      chk("lock_crst", 32'(core_rst), 32'd1);
      press(0, 3, 3);
      press(1, 3, 3);
      for (int i = 0; i < 30 && lockout; i++) step();
      chk("lock_dropped", 32'(lockout), 32'd0);
      chk("lock_cycles", 32'(lock_cyc - base_a), 32'd16);
      chk("lock_crst_cycles", 32'(lock_rst_cyc - base_b), 32'd16);
      chk("lock_no_pulses", 32'(lock_pulses - base_c), 32'd0);
      chk("lock_exit_fail", 32'(fail_count), 32'd0);
      chk("lock_exit_state", 32'(ctrl_state), 32'd0);
      chk("lock_exit_crst", 32'(core_rst), 32'd0);

      // Reset in the 4th cycle of OPEN
      enter_code_ok();
      press(1, 1, 0);
      for (int i = 0; i < 10 && !door_open; i++) step();
      chk("rst_open_reached", 32'(door_open), 32'd1);
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_door", 32'(door_open), 32'd0);
      chk("rst_state", 32'(ctrl_state), 32'd0);
      chk("rst_crst", 32'(core_rst), 32'd1);
      chk("rst_fail", 32'(fail_count), 32'd0);
      step();
      chk("rst_crst_release", 32'(core_rst), 32'd0);

      // Two presses then idle in ENTRY
      press(0, 3, 3);
      press(1, 3, 3);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (core_rst) seen = 1'b1;
      end
`ifdef LOCK_CTRL_TIMEOUT_EN
      chk("timeout_crst", 32'(seen), 32'd1);
      chk("timeout_state", 32'(ctrl_state), 32'd0);
`else
      chk("no_timeout_crst", 32'(seen), 32'd0);
      chk("no_timeout_state", 32'(ctrl_state), 32'd1);
`endif
      chk("timeout_fail", 32'(fail_count), 32'd0);
      chk("b0_b1_exclusive", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
